// File: rtl/fir_tap_sequencer_if.sv
// Control, host-write and memory/MAC strobe bundle of the FIR tap sequencer.
// The sequencer takes the slave side; the host/datapath side takes master.
interface fir_tap_sequencer_if #(
    parameter int ADDR_WIDTH  = 7,
    parameter int COEFF_WIDTH = 16
);
    logic                   start;
    logic                   abort;
    logic [ADDR_WIDTH-1:0]  base_ptr;
    logic                   ready;
    logic                   busy;
    logic                   coeff_wr_req;
    logic [ADDR_WIDTH-1:0]  coeff_wr_addr;
    logic [COEFF_WIDTH-1:0] coeff_wr_data;
    logic                   coeff_wr_ack;
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [COEFF_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0]  smp_addr;
    logic                   mac_valid;
    logic                   mac_first;
    logic                   mac_last;
    logic                   done;

    modport master (
        output start, abort, base_ptr, coeff_wr_req, coeff_wr_addr, coeff_wr_data,
        input  ready, busy, coeff_wr_ack, mem_en, mem_we, mem_addr, mem_wdata,
               smp_addr, mac_valid, mac_first, mac_last, done
    );

    modport slave (
        input  start, abort, base_ptr, coeff_wr_req, coeff_wr_addr, coeff_wr_data,
        output ready, busy, coeff_wr_ack, mem_en, mem_we, mem_addr, mem_wdata,
               smp_addr, mac_valid, mac_first, mac_last, done
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Walks all taps of one FIR output: one coefficient read and sample address per cycle,
// MAC operand flags delayed by the read latency, and host-write arbitration of the memory port.
module fir_tap_sequencer #(
    parameter int TAPS        = 128,
    parameter int ADDR_WIDTH  = 7,
    parameter int COEFF_WIDTH = 16,
    parameter int RD_LATENCY  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fir_tap_sequencer_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  tap;
    logic [ADDR_WIDTH-1:0]  base;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [ADDR_WIDTH-1:0]  smp_addr;
    logic [COEFF_WIDTH-1:0] mem_wdata;
    logic                   ready, busy, ack, mem_en, mem_we, done;
    logic                   vld_p0, first_p0, last_p0;
    logic [RD_LATENCY-1:0]  vld_p, first_p, last_p;
    logic [ADDR_WIDTH-1:0]  next_tap;
    logic                   start_go, wr_go, enter_idle;

    always_comb begin
        next_tap   = tap + ADDR_WIDTH'(1);
        start_go   = bus.start && ready;
        // ack is still high in the cycle the host sees it, so no back-to-back writes
        wr_go      = bus.coeff_wr_req && !ack;
        enter_idle = (state == IDLE && !start_go) || (state == DONE) ||
                     (state != IDLE && bus.abort);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tap       <= '0;
            base      <= '0;
            mem_addr  <= '0;
            smp_addr  <= '0;
            mem_wdata <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            ack       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            vld_p0    <= 1'b0;
            first_p0  <= 1'b0;
            last_p0   <= 1'b0;
            vld_p     <= '0;
            first_p   <= '0;
            last_p    <= '0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            ack      <= 1'b0;
            done     <= 1'b0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            // read-latency stages: index i is the flag i+1 cycles after the read strobe
            vld_p[0]   <= vld_p0;
            first_p[0] <= first_p0;
            last_p[0]  <= last_p0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i]   <= vld_p[i-1];
                first_p[i] <= first_p[i-1];
                last_p[i]  <= last_p[i-1];
            end

            case (state)
                IDLE: begin
                    if (start_go) begin
                        state    <= RUN;
                        base     <= bus.base_ptr;
                        tap      <= '0;
                        mem_en   <= 1'b1;
                        mem_addr <= '0;
                        smp_addr <= bus.base_ptr;
                        vld_p0   <= 1'b1;
                        first_p0 <= 1'b1;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (tap == LAST_TAP) begin
                        state <= DRAIN;
                    end else begin
                        tap      <= next_tap;
                        mem_en   <= 1'b1;
                        mem_addr <= next_tap;
                        smp_addr <= base - next_tap;
                        vld_p0   <= 1'b1;
                        last_p0  <= (next_tap == LAST_TAP);
                    end
                end
                DRAIN: begin
                    if (last_p[RD_LATENCY-1]) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (bus.abort && state != IDLE) begin
                state    <= IDLE;
                mem_en   <= 1'b0;
                done     <= 1'b0;
                vld_p0   <= 1'b0;
                first_p0 <= 1'b0;
                last_p0  <= 1'b0;
                vld_p    <= '0;
                first_p  <= '0;
                last_p   <= '0;
            end

            // first IDLE cycle: a stalled host write takes the port before ready rises
            if (enter_idle) begin
                busy <= 1'b0;
                if (wr_go) begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= bus.coeff_wr_addr;
                    mem_wdata <= bus.coeff_wr_data;
                    ack       <= 1'b1;
                    ready     <= 1'b0;
                end else begin
                    ready <= 1'b1;
                end
            end
        end
    end

    assign bus.ready        = ready;
    assign bus.busy         = busy;
    assign bus.coeff_wr_ack = ack;
    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.smp_addr     = smp_addr;
    assign bus.mac_valid    = vld_p[RD_LATENCY-1];
    assign bus.mac_first    = first_p[RD_LATENCY-1];
    assign bus.mac_last     = last_p[RD_LATENCY-1];
    assign bus.done         = done;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench driving two sequencers (read latency 1 and 3) with shared stimulus.
module tb_fir_tap_sequencer;
    localparam int TAPS = 128;
    localparam int AW   = 7;
    localparam int CW   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_ptr = '0;
    logic [1:0]    req = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [CW-1:0] wr_data = '0;

    fir_tap_sequencer_if #(.ADDR_WIDTH(AW), .COEFF_WIDTH(CW)) bus1 ();
    fir_tap_sequencer_if #(.ADDR_WIDTH(AW), .COEFF_WIDTH(CW)) bus3 ();

    assign bus1.start = start;          assign bus3.start = start;
    assign bus1.abort = abort;          assign bus3.abort = abort;
    assign bus1.base_ptr = base_ptr;    assign bus3.base_ptr = base_ptr;
    assign bus1.coeff_wr_req = req[0];  assign bus3.coeff_wr_req = req[1];
    assign bus1.coeff_wr_addr = wr_addr; assign bus3.coeff_wr_addr = wr_addr;
    assign bus1.coeff_wr_data = wr_data; assign bus3.coeff_wr_data = wr_data;

    fir_tap_sequencer #(.TAPS(TAPS), .ADDR_WIDTH(AW), .COEFF_WIDTH(CW), .RD_LATENCY(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fir_tap_sequencer #(.TAPS(TAPS), .ADDR_WIDTH(AW), .COEFF_WIDTH(CW), .RD_LATENCY(3))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    logic          m_ready[2], m_busy[2], m_ack[2], m_en[2], m_we[2];
    logic          m_mv[2], m_mf[2], m_ml[2], m_done[2];
    logic [AW-1:0] m_addr[2], m_smp[2];
    logic [CW-1:0] m_wdata[2];

    assign m_ready[0] = bus1.ready;      assign m_ready[1] = bus3.ready;
    assign m_busy[0]  = bus1.busy;       assign m_busy[1]  = bus3.busy;
    assign m_ack[0]   = bus1.coeff_wr_ack; assign m_ack[1] = bus3.coeff_wr_ack;
    assign m_en[0]    = bus1.mem_en;     assign m_en[1]    = bus3.mem_en;
    assign m_we[0]    = bus1.mem_we;     assign m_we[1]    = bus3.mem_we;
    assign m_addr[0]  = bus1.mem_addr;   assign m_addr[1]  = bus3.mem_addr;
    assign m_wdata[0] = bus1.mem_wdata;  assign m_wdata[1] = bus3.mem_wdata;
    assign m_smp[0]   = bus1.smp_addr;   assign m_smp[1]   = bus3.smp_addr;
    assign m_mv[0]    = bus1.mac_valid;  assign m_mv[1]    = bus3.mac_valid;
    assign m_mf[0]    = bus1.mac_first;  assign m_mf[1]    = bus3.mac_first;
    assign m_ml[0]    = bus1.mac_last;   assign m_ml[1]    = bus3.mac_last;
    assign m_done[0]  = bus1.done;       assign m_done[1]  = bus3.done;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int rdq[2][$];
    int macq[2][$];
    int wrq[2][$];
    int exp_first[2], exp_last[2], exp_done[2], exp_ack[2];
    int run_lo[2], run_hi[2], mac_cnt[2], done_cnt[2];
    bit active[2];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // scoreboard side: every strobe the DUTs emit is matched against queued expectations
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            string nm;
            int e;
            bit exp_busy;
            nm = $sformatf("L%0d", lat(d));
            if (m_en[d] && !m_we[d]) begin
                if (rdq[d].size() == 0) check({nm, "_rd_extra"}, m_en[d], 1'b0);
                else begin
                    e = rdq[d].pop_front();
                    check({nm, "_rd_addr"}, {m_addr[d], m_smp[d]}, e);
                end
            end
            if (m_ack[d] || m_we[d]) check({nm, "_ack_vs_we"}, m_ack[d], m_en[d] && m_we[d]);
            if (m_en[d] && m_we[d]) begin
                if (wrq[d].size() == 0) check({nm, "_wr_extra"}, m_we[d], 1'b0);
                else begin
                    e = wrq[d].pop_front();
                    check({nm, "_wr_data"}, {m_addr[d], m_wdata[d]}, e);
                    check({nm, "_wr_cycle"}, cyc, exp_ack[d]);
                    check({nm, "_wr_ready"}, m_ready[d], 1'b0);
                end
            end
            if (m_mv[d]) begin
                if (macq[d].size() == 0) check({nm, "_mac_extra"}, m_mv[d], 1'b0);
                else begin
                    e = macq[d].pop_front();
                    check({nm, "_mac_flags"}, {m_mf[d], m_ml[d]}, e);
                    mac_cnt[d]++;
                end
                if (m_mf[d]) check({nm, "_first_cycle"}, cyc, exp_first[d]);
                if (m_ml[d]) check({nm, "_last_cycle"}, cyc, exp_last[d]);
            end
            if (m_done[d]) begin
                check({nm, "_done_cycle"}, cyc, exp_done[d]);
                done_cnt[d]++;
            end
            exp_busy = active[d] && cyc >= run_lo[d] && cyc <= run_hi[d];
            check({nm, "_busy"}, m_busy[d], exp_busy);
        end
    end

    task automatic tick();
        logic [1:0] a;
        @(negedge clk);
        a = {m_ack[1], m_ack[0]};
        @(posedge clk);
        #1;
        req = req & ~a;
    endtask

    task automatic do_start(input int bp);
        logic [AW-1:0] ka, sa;
        start = 1'b1;
        base_ptr = AW'(bp);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < TAPS; k++) begin
                ka = AW'(k);
                sa = AW'(bp - k);
                rdq[d].push_back(int'({ka, sa}));
                macq[d].push_back(int'({k == 0, k == TAPS - 1}));
            end
            exp_first[d] = cyc + 1 + lat(d);
            exp_last[d]  = cyc + TAPS + lat(d);
            exp_done[d]  = cyc + TAPS + lat(d) + 1;
            run_lo[d]    = cyc + 1;
            run_hi[d]    = exp_done[d];
            active[d]    = 1'b1;
            mac_cnt[d]   = 0;
            done_cnt[d]  = 0;
        end
    endtask

    task automatic wr_issue(input int a, input int dat, input bit deferred);
        wr_addr = AW'(a);
        wr_data = CW'(dat);
        req = 2'b11;
        for (int d = 0; d < 2; d++) begin
            wrq[d].push_back(int'({wr_addr, wr_data}));
            exp_ack[d] = deferred ? exp_done[d] + 1 : cyc + 1;
        end
    endtask

    task automatic run_wait(input int n, input int ign);
        for (int i = 1; i <= n; i++) begin
            tick();
            start = (i == ign);
        end
        start = 1'b0;
    endtask

    task automatic wait_wr();
        for (int i = 0; i < 300 && req != 2'b00; i++) tick();
        check("wr_req_dropped", req, 2'b00);
        for (int d = 0; d < 2; d++) check($sformatf("L%0d_wrq_empty", lat(d)), wrq[d].size(), 0);
    endtask

    task automatic end_run(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_L%0d_rdq_empty", tag, lat(d)), rdq[d].size(), 0);
            check($sformatf("%s_L%0d_macq_empty", tag, lat(d)), macq[d].size(), 0);
            check($sformatf("%s_L%0d_mac_count", tag, lat(d)), mac_cnt[d], TAPS);
            check($sformatf("%s_L%0d_done_count", tag, lat(d)), done_cnt[d], 1);
            check($sformatf("%s_L%0d_ready_after", tag, lat(d)), m_ready[d], 1'b1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++)
            check($sformatf("%s_L%0d_outputs", tag, lat(d)),
                  {m_ready[d], m_busy[d], m_ack[d], m_en[d], m_we[d], m_addr[d], m_wdata[d],
                   m_smp[d], m_mv[d], m_mf[d], m_ml[d], m_done[d]}, '0);
    endtask

    task automatic check_ready(input string tag, input logic v);
        for (int d = 0; d < 2; d++) check($sformatf("%s_L%0d", tag, lat(d)), m_ready[d], v);
    endtask

    task automatic drop_run();
        for (int d = 0; d < 2; d++) begin
            rdq[d].delete();
            macq[d].delete();
            exp_done[d] = -1;
            exp_last[d] = -1;
            run_hi[d] = cyc - 1;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            exp_done[d] = -1; exp_last[d] = -1; exp_first[d] = -1; exp_ack[d] = -1;
            run_lo[d] = 0; run_hi[d] = -1; active[d] = 1'b0;
        end
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        check_ready("ready_in_reset_release", 1'b0);
        tick();
        check_ready("ready_first_edge", 1'b1);

        // full run, base 5, with an ignored start in the middle
        do_start(5);
        run_wait(136, 50);
        end_run("run_b5");

        // idle host write
        wr_issue(8'h10, 16'hABCD, 1'b0);
        wait_wr();
        check_ready("ready_after_write", 1'b1);

        // start and write in the same cycle: start wins, write lands after done
        do_start(100);
        wr_issue(8'h2A, 16'h1234, 1'b1);
        run_wait(136, 0);
        wait_wr();
        end_run("run_b100_wr");

        // abort at tap 60
        do_start(33);
        run_wait(61, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drop_run();
        check_ready("ready_after_abort", 1'b1);
        run_wait(10, 0);
        for (int d = 0; d < 2; d++) check($sformatf("abort_L%0d_no_done", lat(d)), done_cnt[d], 0);
        do_start(7);
        run_wait(136, 0);
        end_run("run_after_abort");

        // asynchronous reset at tap 30
        do_start(64);
        run_wait(31, 0);
        #1;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) active[d] = 1'b0;
        drop_run();
        #1;
        check_all_zero("async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        check_ready("ready_held_low", 1'b0);
        tick();
        check_ready("ready_after_reset", 1'b1);
        do_start(0);
        run_wait(136, 0);
        end_run("run_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Sequences one filter output computation across all TAPS taps for the FIR datapath. Per start, it issues one coefficient-memory read and one sample-buffer address per cycle. It tags the returning MAC operands with valid/first/last flags and pulses done once the last operand has left the read pipeline. It also arbitrates the single coefficient-memory port between host programming writes and computation reads.

Parameters:
TAPS, 128, number of taps; must be a power of two, minimum 4
ADDR_WIDTH, 7, log2(TAPS); width of coefficient and sample addresses
COEFF_WIDTH, 16, coefficient data width
RD_LATENCY, 1, coefficient/sample read latency in cycles; legal values 1..3

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to compute one output
abort  in  1  synchronous abort of the current computation
base_ptr  in  ADDR_WIDTH  sample-buffer index of the newest sample
ready  out  1  high in IDLE with no write being performed; start is accepted only when ready=1
busy  out  1  high in RUN, DRAIN and DONE
coeff_wr_req  in  1  host write request; the host holds req, addr and data stable until ack
coeff_wr_addr  in  ADDR_WIDTH  host write address
coeff_wr_data  in  COEFF_WIDTH  host write data
coeff_wr_ack  out  1  one-cycle pulse in the cycle the write is performed on the memory port
mem_en  out  1  coefficient memory enable
mem_we  out  1  coefficient memory write enable
mem_addr  out  ADDR_WIDTH  coefficient memory address
mem_wdata  out  COEFF_WIDTH  coefficient memory write data
smp_addr  out  ADDR_WIDTH  sample-buffer read address
mac_valid  out  1  MAC operands valid this cycle
mac_first  out  1  with mac_valid: operand of tap 0; the MAC clears its accumulator
mac_last  out  1  with mac_valid: operand of tap TAPS-1
done  out  1  one-cycle pulse when the computation is complete

Behaviour:
- All outputs are registered.
- Reset: state IDLE, tap counter 0, all outputs 0. ready becomes 1 on the first clock edge after rst_n deasserts.
- Clock, reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, no start, coeff_wr_req=1: drive mem_en=1, mem_we=1, mem_addr and mem_wdata from the host in the next cycle, and pulse coeff_wr_ack in that same cycle. ready=0 in the write cycle. One write per two cycles maximum; the host drops req after ack.
- start handling: start with ready=1 latches base_ptr and goes to RUN. start together with coeff_wr_req in IDLE: start wins and the write waits until IDLE. start while ready=0 is ignored and not queued.
- RUN, tap k = 0..TAPS-1, one per cycle: mem_en=1, mem_we=0, mem_addr=k, smp_addr=(base_latched - k) mod TAPS (natural wrap at ADDR_WIDTH). After k=TAPS-1, go to DRAIN.
- MAC flags: mac_valid/first/last are the RUN read strobes delayed by RD_LATENCY through a shift pipeline. mac_first marks k=0; mac_last marks k=TAPS-1.
- DRAIN: stay until mac_last has been emitted, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Timing (start sampled in cycle 0): first mem read in cycle 1, last read in cycle TAPS, first mac_valid in cycle 1+RD_LATENCY, mac_last in cycle TAPS+RD_LATENCY, done in cycle TAPS+RD_LATENCY+1. The earliest next start is accepted in cycle TAPS+RD_LATENCY+2.
- Host writes during RUN/DRAIN/DONE are stalled with no ack. They are serviced on the first IDLE cycle, so the coefficients never change mid-computation.
- abort: in any non-IDLE state, abort forces IDLE on the next edge. It flushes the valid pipeline, so no further mac_valid, no mac_last, and no done are produced. abort in IDLE has no effect and does not cancel a pending write.
- Reset mid-computation: reset immediately clears all outputs and the pipeline, and the state returns to IDLE.
- busy=1 exactly from the first RUN cycle through the DONE cycle inclusive.

Test Plan:
1. Reset, then TAPS=128, RD_LATENCY=1, base_ptr=5, start in cycle 0 -> mem_addr runs 0..127 in cycles 1..128; smp_addr runs 5,4,..,0,127,..,6; mac_first in cycle 2, mac_last in cycle 129, done in cycle 130; exactly 128 mac_valid.
2. Idle host write addr=0x10, data=0xABCD -> in the next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xABCD, coeff_wr_ack=1 for one cycle; ready=0 in that cycle.
3. start and coeff_wr_req in the same IDLE cycle -> the computation runs with no ack during it; the write is acked in the first IDLE cycle after done.
4. abort asserted at tap k=60 -> IDLE next cycle; mac_valid stays 0 after the in-flight entries are flushed; done and mac_last are never asserted; a new start is accepted.
5. RD_LATENCY=3, base_ptr=0 -> mac_first in cycle 4, mac_last in cycle 131, done in cycle 132; start in cycle 50 is ignored.
6. rst_n low at tap 30 -> all outputs 0 asynchronously; after release ready=1 and a normal run completes.
